// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stability-count filter FSM; emits a
// debounced level, one-cycle rise/fall strobes and a saturating glitch count.
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter int GLITCH_W      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                raw_in,
  input  logic                en,
  input  logic                glitch_clr,
  output logic                d_out,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_count
);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    CHECK_HIGH  = 2'd1,
    HIGH_STABLE = 2'd2,
    CHECK_LOW   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    LAST_CNT   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

  logic             s1_r;
  logic             s2_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             glitch_evt_s;

  // A glitch is an enabled check aborted because s2 fell back to the held level.
  always_comb begin
    glitch_evt_s = 1'b0;
    case (state_r)
      CHECK_HIGH: glitch_evt_s = en & ~s2_r;
      CHECK_LOW:  glitch_evt_s = en & s2_r;
      default:    glitch_evt_s = 1'b0;
    endcase
  end

  // Synchroniser, filter FSM, strobes and glitch counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_r         <= 1'b0;
      s2_r         <= 1'b0;
      state_r      <= LOW_STABLE;
      cnt_r        <= '0;
      d_out        <= 1'b0;
      rise         <= 1'b0;
      fall         <= 1'b0;
      glitch_count <= '0;
    end else begin
      s1_r <= raw_in;
      s2_r <= s1_r;
      rise <= 1'b0;
      fall <= 1'b0;

      case (state_r)
        LOW_STABLE: begin
          if (en && s2_r) begin
            state_r <= CHECK_HIGH;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r   <= '0;
          end
        end
        CHECK_HIGH: begin
          if (!en || !s2_r) begin
            state_r <= LOW_STABLE;
            cnt_r   <= '0;
          end else if (cnt_r == LAST_CNT) begin
            state_r <= HIGH_STABLE;
            d_out   <= 1'b1;
            rise    <= 1'b1;
            cnt_r   <= '0;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        HIGH_STABLE: begin
          if (en && !s2_r) begin
            state_r <= CHECK_LOW;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r   <= '0;
          end
        end
        CHECK_LOW: begin
          if (!en || s2_r) begin
            state_r <= HIGH_STABLE;
            cnt_r   <= '0;
          end else if (cnt_r == LAST_CNT) begin
            state_r <= LOW_STABLE;
            d_out   <= 1'b0;
            fall    <= 1'b1;
            cnt_r   <= '0;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= LOW_STABLE;
          cnt_r   <= '0;
          d_out   <= 1'b0;
        end
      endcase

      // Clear takes precedence over a coincident glitch; count never wraps.
      if (glitch_clr) begin
        glitch_count <= '0;
      end else if (glitch_evt_s && (glitch_count != GLITCH_MAX)) begin
        glitch_count <= glitch_count + GLITCH_W'(1);
      end else begin
        glitch_count <= glitch_count;
      end
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Randomised and directed bench for input_debouncer, checked every cycle
// against a run-length reference model of the debounce rules.
module tb_input_debouncer;
  localparam int STABLE = 4;
  localparam int GW     = 8;
  localparam int GMAX   = (1 << GW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          raw_in;
  logic          en;
  logic          glitch_clr;
  logic          d_out;
  logic          rise;
  logic          fall;
  logic [GW-1:0] glitch_count;

  always #5 clock = ~clock;

  input_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(16), .GLITCH_W(GW)) dut (
    .clock(clock), .reset(reset), .raw_in(raw_in), .en(en),
    .glitch_clr(glitch_clr), .d_out(d_out), .rise(rise), .fall(fall),
    .glitch_count(glitch_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: pipeline of raw samples plus the length of the current
  // enabled run of synchronised samples that disagree with the output level.
  bit m_s1 = 1'b0, m_s2 = 1'b0, m_d = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int m_run = 0, m_glitch = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_step();
    bit evt;
    evt = 1'b0;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_d = 0; m_rise = 0; m_fall = 0; m_run = 0; m_glitch = 0;
    end else begin
      m_rise = 0;
      m_fall = 0;
      if (en && (m_s2 != m_d)) begin
        m_run++;
        if (m_run == STABLE) begin
          m_d    = m_s2;
          m_rise = m_s2;
          m_fall = !m_s2;
          m_run  = 0;
        end
      end else begin
        if (en && m_run > 0) evt = 1'b1;
        m_run = 0;
      end
      if (glitch_clr) m_glitch = 0;
      else if (evt && m_glitch < GMAX) m_glitch++;
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    cyc++;
    @(negedge clock);
    check("d_out", 32'(d_out), 32'(m_d));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("glitch_count", 32'(glitch_count), 32'(m_glitch));
    if (rise === 1'b1 && fall === 1'b1) check("rise_fall_exclusive", 32'd1, 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until the requested strobe appears; returns cycles taken or -1.
  task automatic wait_strobe(input bit want_rise, input int limit, output int lat);
    int t0;
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (lat < 0 && ((want_rise && rise === 1'b1) || (!want_rise && fall === 1'b1)))
        lat = cyc - t0;
    end
  endtask

  int lat;
  int seg;

  initial begin
    reset = 1'b1; raw_in = 1'b0; en = 1'b1; glitch_clr = 1'b0;
    ticks(2);
    reset = 1'b0;
    tick();
    check("reset_d_out", 32'(d_out), 32'd0);
    check("reset_glitch", 32'(glitch_count), 32'd0);
    ticks(5);

    // Rise latency: six edges counting the first one that sees the new level.
    raw_in = 1'b1;
    wait_strobe(1'b1, 10, lat);
    check("rise_latency", 32'(lat), 32'd6);
    check("high_d_out", 32'(d_out), 32'd1);

    raw_in = 1'b0;
    wait_strobe(1'b0, 10, lat);
    check("fall_latency", 32'(lat), 32'd6);
    check("low_d_out", 32'(d_out), 32'd0);

    // 300 two-cycle pulses: one glitch each, saturating at the maximum.
    for (int i = 0; i < 300; i++) begin
      raw_in = 1'b1; ticks(2);
      raw_in = 1'b0; ticks(4);
      if (i == 0) check("first_glitch", 32'(glitch_count), 32'd1);
    end
    check("glitch_saturated", 32'(glitch_count), 32'(GMAX));
    check("glitch_d_out", 32'(d_out), 32'd0);
    glitch_clr = 1'b1; tick(); glitch_clr = 1'b0;
    check("glitch_cleared", 32'(glitch_count), 32'd0);

    // Abort a pending check with en=0, then a full new check on re-enable.
    raw_in = 1'b1; ticks(4);
    en = 1'b0; ticks(3);
    check("abort_no_glitch", 32'(glitch_count), 32'd0);
    check("abort_d_out", 32'(d_out), 32'd0);
    en = 1'b1;
    wait_strobe(1'b1, 8, lat);
    check("reenable_latency", 32'(lat), 32'd4);

    // Reset in the middle of a high-to-low check.
    raw_in = 1'b0; ticks(4);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midcheck_reset_d_out", 32'(d_out), 32'd0);
    check("midcheck_reset_fall", 32'(fall), 32'd0);

    // Glitch event coinciding with glitch_clr: the clear wins.
    raw_in = 1'b1; ticks(3); raw_in = 1'b0; ticks(4);
    check("pre_clear_glitch", 32'(glitch_count), 32'd1);
    raw_in = 1'b1; ticks(3); raw_in = 1'b0; ticks(2);
    glitch_clr = 1'b1; tick(); glitch_clr = 1'b0;
    check("clear_beats_glitch", 32'(glitch_count), 32'd0);
    ticks(3);

    // Random segments of raw levels with occasional enable drops, clears, resets.
    for (int s = 0; s < 500; s++) begin
      raw_in = 1'($urandom_range(0, 1));
      seg    = $urandom_range(1, 8);
      for (int j = 0; j < seg; j++) begin
        en         = ($urandom_range(0, 9) != 0);
        glitch_clr = ($urandom_range(0, 49) == 0);
        reset      = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    reset = 1'b0; en = 1'b1; glitch_clr = 1'b0;
    ticks(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Front-end conditioning stage that produces the clean `d_in` level consumed directly by the sequence/edge-detector FSM.
- Synchronises an asynchronous raw pin with two flops, then filters it with a stability-count FSM.
- Outputs a debounced level plus single-cycle rise/fall strobes.
- Keeps a saturating count of rejected glitches for debug/status readback.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised cycles a new level must hold before it is accepted. Legal range 2..65535.
- CNT_W, 16, width of the internal stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES.
- GLITCH_W, 8, width of the glitch counter.

Ports:
- clock  input  1  single system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- raw_in  input  1  asynchronous raw input (switch/pin)
- en  input  1  filter enable; 0 aborts any pending check
- glitch_clr  input  1  synchronous clear of glitch_count
- d_out  output  1  debounced level (registered)
- rise  output  1  one-cycle pulse when d_out goes 0->1
- fall  output  1  one-cycle pulse when d_out goes 1->0
- glitch_count  output  GLITCH_W  number of aborted checks, saturating

Behaviour:
- One clock domain; reset is synchronous and active-high. Clock port is `clock`, reset port is `reset`; polarity and synchronicity are fixed.
- Reset (highest priority), applied on the clock edge:
  - s1, s2 = 0
  - state = LOW_STABLE, cnt = 0
  - d_out = 0, rise = 0, fall = 0, glitch_count = 0
- Synchroniser: s1 <= raw_in; s2 <= s1. The FSM sees only s2.
- FSM states: LOW_STABLE, CHECK_HIGH, HIGH_STABLE, CHECK_LOW.
- LOW_STABLE:
  - If en=1 and s2=1: go to CHECK_HIGH, cnt <= 1.
  - Otherwise stay, cnt = 0.
- CHECK_HIGH:
  - If en=0: go to LOW_STABLE, cnt <= 0. Not counted as a glitch.
  - Else if s2=0: go to LOW_STABLE, cnt <= 0, glitch_count += 1 (saturating).
  - Else if cnt == STABLE_CYCLES-1: go to HIGH_STABLE, d_out <= 1, rise <= 1, cnt <= 0.
  - Else: cnt <= cnt+1.
- HIGH_STABLE and CHECK_LOW mirror LOW_STABLE and CHECK_HIGH with polarity inverted. The accepting transition sets d_out <= 0 and fall <= 1.
- rise and fall are registered and high for exactly one cycle; both return to 0 the next cycle. They are never both high in the same cycle.
- Latency: raw_in stable at 1 from edge k gives d_out = 1 and rise = 1 after edge k+STABLE_CYCLES+1. With the default of 4, that is 6 edges counting edge k. Falling direction has identical latency.
- A pulse on s2 shorter than STABLE_CYCLES cycles never changes d_out and increments glitch_count by 1.
- glitch_count saturates at 2^GLITCH_W-1 and does not wrap.
- If glitch_clr and a glitch event occur in the same cycle, the clear wins and glitch_count = 0.
- en=0:
  - Synchroniser keeps running.
  - d_out holds its value.
  - No rise/fall strobes are produced.
  - Any pending check is discarded without counting a glitch.
- When en returns to 1 with s2 differing from d_out, a full new check starts (cnt = 1 on the first enabled cycle).
- Reset asserted mid-check discards the check: d_out = 0 even if it was 1, and no fall pulse is generated.

Test Plan:
- Reset held 2 cycles, raw_in=0 -> d_out=0, rise=fall=0, glitch_count=0 on the first cycle after reset.
- raw_in 0->1 at edge 10, held, STABLE_CYCLES=4 -> rise=1 only in the cycle after edge 15; d_out=1 from then on; glitch_count stays 0.
- With d_out=0, raw_in high for 2 cycles then low -> d_out stays 0, no rise, glitch_count=1. Repeat 300 times -> glitch_count=255 (saturated).
- With d_out=1, raw_in low steadily -> fall=1 for exactly one cycle 6 edges after the change; d_out=0.
- raw_in goes high, then en=0 after 2 cycles of checking -> state returns to LOW_STABLE and glitch_count is unchanged. Set en=1 with raw_in still high -> rise appears 4 cycles later.
- Reset asserted while d_out=1 and in CHECK_LOW -> next cycle d_out=0, fall=0. Also drive glitch_clr=1 with a simultaneous glitch -> glitch_count=0.
